// File: rtl/alert_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg : shared types and defaults for the buzzer alert arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } arb_state_e;

  localparam int SRC_TIMER = 0;
  localparam int SRC_ALARM = 1;
  localparam int SRC_CHIME = 2;

  localparam int N_REQ_DEFAULT     = 3;
  localparam int TIMEOUT_S_DEFAULT = 60;
  localparam int SNOOZE_S_DEFAULT  = 300;

endpackage

`default_nettype wire

// File: rtl/alert_arbiter_if.sv
// ---------------------------------------------------------------------------
// alert_arbiter_if : alert sources / user button <-> buzzer arbiter bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alert_arbiter_if
  import clock_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) ();

  logic             tick_1hz;
  logic [N_REQ-1:0] req;
  logic             ack;
  logic             snooze;
  logic             buzzer;
  logic [N_REQ-1:0] active_src;
  logic [N_REQ-1:0] ack_out;
  logic             missed;
  logic [N_REQ-1:0] pending;

  modport master (
    output tick_1hz, req, ack, snooze,
    input  buzzer, active_src, ack_out, missed, pending
  );

  modport slave (
    input  tick_1hz, req, ack, snooze,
    output buzzer, active_src, ack_out, missed, pending
  );

endinterface

`default_nettype wire

// File: rtl/alert_arbiter_sec_down_counter.sv
// ---------------------------------------------------------------------------
// sec_down_counter : loadable, tick-enabled seconds counter, holds at 0.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sec_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Fires on the tick that takes the count from 1 to 0, so the owner can act that cycle.
  assign expire = tick && !load && (cnt_q == W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alert_arbiter.sv
// ---------------------------------------------------------------------------
// alert_arbiter : shares the buzzer between timer, alarm and chime alerts.
// Optional cadence per source with BUZZ_PATTERN_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alert_arbiter
  import clock_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT,
  parameter int SNOOZE_S  = SNOOZE_S_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  alert_arbiter_if.slave bus
);

  localparam int CW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    cur_q, cur_d, sel;
  logic [N_REQ-1:0] req_q, req_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] ack_out_q, ack_out_d;
  logic [N_REQ-1:0] cur_oh;
  logic             missed_q, missed_d;
  logic             higher, to_load, sn_load, to_exp, sn_exp;

  assign cur_oh = N_REQ'(1) << cur_q;

  always_comb begin
    sel    = '0;
    higher = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = CW'(i);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (pending_q[i] && (i < int'(cur_q))) higher = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ack_out_d = '0;
    missed_d  = 1'b0;
    to_load   = 1'b0;
    sn_load   = 1'b0;
    req_d     = bus.req;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          cur_d   = sel;
          to_load = 1'b1;
          state_d = RING;
        end
      end
      RING: begin
        if (bus.ack) begin
          ack_out_d = cur_oh;
          state_d   = IDLE;
        end else if (bus.snooze) begin
          sn_load = 1'b1;
          state_d = SNOOZE;
        end else if (to_exp) begin
          ack_out_d = cur_oh;
          missed_d  = 1'b1;
          state_d   = IDLE;
        end
      end
      SNOOZE: begin
        // A more urgent source breaks the snooze; the snoozed one stays pending.
        if (bus.ack) begin
          ack_out_d = cur_oh;
          state_d   = IDLE;
        end else if (higher) begin
          state_d = IDLE;
        end else if (sn_exp) begin
          to_load = 1'b1;
          state_d = RING;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | (bus.req & ~req_q)) & ~ack_out_d;
  end

  sec_down_counter #(.W(8)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (to_load),
    .load_val (8'(TIMEOUT_S)),
    .tick     (bus.tick_1hz && (state_q == RING)),
    .expire   (to_exp)
  );

  sec_down_counter #(.W(10)) u_snooze (
    .clk      (clk),
    .reset    (reset),
    .load     (sn_load),
    .load_val (10'(SNOOZE_S)),
    .tick     (bus.tick_1hz && (state_q == SNOOZE)),
    .expire   (sn_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      req_q     <= '0;
      pending_q <= '0;
      ack_out_q <= '0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      ack_out_q <= ack_out_d;
      missed_q  <= missed_d;
    end
  end

`ifdef BUZZ_PATTERN_EN
  logic pat_q, pat_d;

  always_comb begin
    pat_d = pat_q;
    if (to_load) begin
      pat_d = 1'b1;
    end else if ((state_q == RING) && bus.tick_1hz) begin
      if (cur_q == CW'(SRC_TIMER)) begin
        pat_d = ~pat_q;
      end else if (cur_q == CW'(SRC_CHIME)) begin
        pat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q <= 1'b0;
    end else begin
      pat_q <= pat_d;
    end
  end

  assign bus.buzzer = (state_q == RING) && pat_q;
`else
  assign bus.buzzer = (state_q == RING);
`endif

  assign bus.active_src = (state_q != IDLE) ? cur_oh : '0;
  assign bus.ack_out    = ack_out_q;
  assign bus.missed     = missed_q;
  assign bus.pending    = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_alert_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alert_arbiter : directed vectors against an event-level model of the arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alert_arbiter;

  localparam int TO = 4;
  localparam int SN = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  bit   cmp_en = 1'b0;

  alert_arbiter_if #(.N_REQ(3)) bus ();

  alert_arbiter #(.N_REQ(3), .TIMEOUT_S(TO), .SNOOZE_S(SN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: which source is being served (-1 = none), whether it is snoozed,
  // seconds left on whichever wait is running, and the pending set.
  int         m_cur;
  bit         m_snz;
  int         m_secs;
  logic [2:0] m_pend, m_prev, m_ackp;
  logic       m_miss;

  function automatic int lowest(input logic [2:0] p);
    for (int i = 0; i < 3; i++) if (p[i]) return i;
    return 3;
  endfunction

  task automatic model_reset();
    m_cur = -1; m_snz = 1'b0; m_secs = 0;
    m_pend = '0; m_prev = '0; m_ackp = '0; m_miss = 1'b0;
  endtask

  task automatic model_update(input logic [2:0] r, input logic a, input logic s, input logic t);
    int         served;
    logic [2:0] np;
    served = -1;
    np     = m_pend | (r & ~m_prev);
    m_ackp = '0;
    m_miss = 1'b0;
    if (m_cur < 0) begin
      if (m_pend != 0) begin m_cur = lowest(m_pend); m_snz = 1'b0; m_secs = TO; end
    end else if (a) begin
      served = m_cur;
    end else if (!m_snz) begin
      if (s) begin m_snz = 1'b1; m_secs = SN; end
      else if (t) begin
        m_secs--;
        if (m_secs == 0) begin served = m_cur; m_miss = 1'b1; end
      end
    end else begin
      if (lowest(m_pend) < m_cur) m_cur = -1;
      else if (t) begin
        m_secs--;
        if (m_secs == 0) begin m_snz = 1'b0; m_secs = TO; end
      end
    end
    if (served >= 0) begin m_ackp[served] = 1'b1; np[served] = 1'b0; m_cur = -1; end
    m_pend = np;
    m_prev = r;
  endtask

  function automatic logic model_buzz();
    if (m_cur < 0 || m_snz) return 1'b0;
`ifdef BUZZ_PATTERN_EN
    if (m_cur == 0) return ((TO - m_secs) % 2) == 0;
    if (m_cur == 2) return (TO - m_secs) == 0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [10:0] model_vec();
    logic [2:0] act;
    act = (m_cur >= 0) ? 3'(1 << m_cur) : 3'b000;
    return {model_buzz(), act, m_ackp, m_miss, m_pend};
  endfunction

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      n_vec++;
      if ({bus.buzzer, bus.active_src, bus.ack_out, bus.missed, bus.pending} !== model_vec()) begin
        n_err++;
        $display("FAIL cycle t=%0t got buz/act/ackout/miss/pend=%b/%b/%b/%b/%b required %b",
                 $time, bus.buzzer, bus.active_src, bus.ack_out, bus.missed, bus.pending, model_vec());
      end
    end
  end

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %b required %b", name, $time, got, exp);
    end
  endtask

  task automatic step();
    logic [2:0] r;
    logic       a, s, t;
    r = bus.req; a = bus.ack; s = bus.snooze; t = bus.tick_1hz;
    @(posedge clk);
    if (reset) model_reset();
    else model_update(r, a, s, t);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic sec();
    steps(9);
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.tick_1hz = 1'b0; bus.req = '0; bus.ack = 1'b0; bus.snooze = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    chk("rst_pending", bus.pending, 3'b000);
    chk("rst_buzz_act", {bus.buzzer, bus.missed, |bus.active_src}, 3'b000);

    // Basic ring and acknowledge
    bus.req = 3'b001; step();
    chk("pend_set", bus.pending, 3'b001);
    chk("buzz_lat1", {2'b00, bus.buzzer}, 3'b000);
    step();
    chk("buzz_lat2", {2'b00, bus.buzzer}, 3'b001);
    chk("act_timer", bus.active_src, 3'b001);
    steps(3); do_ack();
    chk("ack_out", bus.ack_out, 3'b001);
    chk("ack_clear", {bus.buzzer, 2'b00} | bus.pending, 3'b000);
    bus.req = 3'b000; steps(2);

    // Timeout reported as missed; held request does not re-ring
    bus.req = 3'b001; steps(2);
    sec(); sec(); sec();
    chk("to_still_ring", {bus.missed, 1'b0, bus.buzzer}, 3'b001);
    sec();
    chk("missed", {bus.missed, 1'b0, bus.buzzer}, 3'b100);
    chk("missed_ackout", bus.ack_out, 3'b001);
    steps(5);
    chk("held_no_rering", {bus.buzzer, 2'b00} | bus.pending, 3'b000);
    bus.req = 3'b000; step();

    // Snooze then re-ring
    bus.req = 3'b001; steps(2);
    bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
    chk("snz_quiet", {bus.buzzer, 2'b00} | bus.pending, 3'b001);
    chk("snz_act", bus.active_src, 3'b001);
    bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
    sec(); sec();
    chk("snz_2s", {2'b00, bus.buzzer}, 3'b000);
    sec();
    chk("snz_rering", {2'b00, bus.buzzer}, 3'b001);
    chk("snz_rering_act", bus.active_src, 3'b001);
    do_ack();
    chk("snz_ack_pend", bus.pending, 3'b000);
    bus.req = 3'b000; step();

    // Higher-priority edge during RING waits for the current alert
    bus.req = 3'b100; steps(2);
    chk("chime_act", bus.active_src, 3'b100);
    bus.req = 3'b101; step();
    chk("no_preempt_pend", bus.pending, 3'b101);
    steps(3);
    chk("no_preempt_act", bus.active_src, 3'b100);
    do_ack();
    chk("chime_ackout", bus.ack_out, 3'b100);
    chk("b2b_gap", bus.active_src, 3'b000);
    step();
    chk("b2b_timer", bus.active_src, 3'b001);
    do_ack();
    bus.req = 3'b000; step();

    // Snoozed alarm is preempted by timer, then re-rings
    bus.req = 3'b010; steps(2);
    bus.snooze = 1'b1; step(); bus.snooze = 1'b0;
    chk("alarm_snz", bus.active_src, 3'b010);
    bus.req = 3'b011; step();
    chk("snz_hold", bus.active_src, 3'b010);
    step();
    chk("rearb_idle", bus.active_src, 3'b000);
    step();
    chk("rearb_timer", bus.active_src, 3'b001);
    do_ack();
    chk("rearb_pend", bus.pending, 3'b010);
    step();
    chk("alarm_rering", bus.active_src, 3'b010);
    do_ack();
    bus.req = 3'b000; step();

    // ack and snooze together: ack wins
    bus.req = 3'b001; steps(2);
    bus.ack = 1'b1; bus.snooze = 1'b1; step(); bus.ack = 1'b0; bus.snooze = 1'b0;
    chk("ack_beats_snz", bus.ack_out, 3'b001);
    chk("ack_beats_snz_st", {bus.buzzer, 2'b00} | bus.active_src, 3'b000);
    bus.req = 3'b000; step();

    // ack on the final timeout tick: no missed pulse
    bus.req = 3'b001; steps(2);
    sec(); sec(); sec();
    steps(9);
    bus.tick_1hz = 1'b1; bus.ack = 1'b1; step(); bus.tick_1hz = 1'b0; bus.ack = 1'b0;
    chk("ack_tick_ackout", bus.ack_out, 3'b001);
    chk("ack_tick_missed", {2'b00, bus.missed}, 3'b000);
    bus.req = 3'b000; steps(2);

    // ack/snooze in IDLE do nothing
    bus.ack = 1'b1; bus.snooze = 1'b1; step(); bus.ack = 1'b0; bus.snooze = 1'b0;
    chk("idle_ack", bus.ack_out | bus.active_src, 3'b000);

    // Asynchronous reset mid-ring
    bus.req = 3'b100; steps(2);
    chk("pre_rst_buzz", {2'b00, bus.buzzer}, 3'b001);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_buzz", {bus.buzzer, 2'b00} | bus.active_src, 3'b000);
    chk("async_rst_pend", bus.pending, 3'b000);
    model_reset();
    @(negedge clk);
    bus.req = 3'b000; step();
    reset = 1'b0;
    steps(3);
    chk("post_rst", bus.pending | bus.active_src, 3'b000);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alert_arbiter.md
Name: alert_arbiter

Overview:
- Shares the single board buzzer between alert sources: countdown timer expiry, alarm match and hourly chime.
- Latches each source's rising edge as a pending alert and rings the highest-priority pending source.
- The user acknowledges or snoozes the ringing alert through the startstop button, already debounced and edge-detected.
- Unanswered alerts time out and are reported as missed.

Parameters:
- N_REQ, 3, number of alert sources; index 0 is highest priority.
- TIMEOUT_S, 60, seconds a source rings before auto-clearing as missed; range 1..255.
- SNOOZE_S, 300, seconds of snooze before re-ringing; range 1..1023.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- tick_1hz  in  1  one-clk enable pulse per second, clk domain.
- req  in  N_REQ  level alert requests; bit0 timer, bit1 alarm, bit2 chime.
- ack  in  1  one-clk pulse: acknowledge the ringing alert.
- snooze  in  1  one-clk pulse: snooze the ringing alert.
- buzzer  out  1  buzzer drive.
- active_src  out  N_REQ  one-hot source currently ringing or snoozed; 0 when IDLE.
- ack_out  out  N_REQ  one-clk pulse to the served source, telling it to clear its request.
- missed  out  1  one-clk pulse when an alert times out.
- pending  out  N_REQ  registered pending vector.

Behaviour:
- Reset values: all outputs 0; state IDLE; pending 0; counters 0; previous-req register 0.
- Request capture:
  - pending[i] sets on a 0→1 edge of req[i], detected against the registered req of the previous cycle.
  - A level held after service does not re-set pending.
  - An edge on a source already pending is ignored.
- FSM state IDLE:
  - If pending is nonzero, select the lowest-index pending source as cur.
  - Next cycle: RING; load the second counter with TIMEOUT_S; active_src = onehot(cur).
  - Latency: edge on req → buzzer high in 2 clk cycles.
- FSM state RING:
  - buzzer = 1 (see the optional feature for patterned drive).
  - Counter decrements on tick_1hz.
  - On ack: pulse ack_out[cur] for one cycle, clear pending[cur], go to IDLE.
  - On snooze: buzzer drops next cycle; load the counter with SNOOZE_S; go to SNOOZE; pending[cur] stays set.
  - On the counter reaching 0 at a tick: treat as ack and also pulse missed.
- FSM state SNOOZE:
  - buzzer = 0; counter decrements on tick_1hz.
  - On counter expiry: return to RING for cur with TIMEOUT_S reloaded.
  - If a source with index lower than cur becomes pending, go to IDLE and re-arbitrate; the snoozed source stays pending.
  - ack during SNOOZE cancels the alert as in RING.
  - snooze during SNOOZE is ignored (the counter is not reloaded).
- Simultaneous events:
  - ack beats snooze.
  - ack beats timeout in the same cycle; missed is not pulsed.
  - A higher-priority edge arriving during RING does not preempt; it is served after the current alert clears.
- ack or snooze in IDLE: no effect.
- Asynchronous reset mid-RING: buzzer 0 immediately; all pending alerts are lost.
- Counter widths: 8 bits for timeout, 10 bits for snooze; no wrap, hold at 0.
- IDLE→RING back-to-back: after clearing one alert, the next pending source rings 2 cycles later.

Optional Feature:
- Macro BUZZ_PATTERN_EN.
- Defined: in RING, the buzzer follows a per-source cadence.
  - Timer: toggles every tick, 1 s on / 1 s off, starting on.
  - Alarm: steady on.
  - Chime: on for the first tick interval only, then silent until ack or timeout.
- Undefined: buzzer is steady 1 throughout RING for all sources.

Decomposition:
- Package clock_pkg:
  - FSM state enum (IDLE, RING, SNOOZE).
  - Source indices SRC_TIMER=0, SRC_ALARM=1, SRC_CHIME=2.
  - Default TIMEOUT_S and SNOOZE_S constants.
- One sub-module: sec_down_counter.
  - Loadable, tick-enabled, saturating at 0.
  - Provides an expiry pulse.
  - Reused for both timeout and snooze.

Test Plan (TIMEOUT_S=4, SNOOZE_S=3, tick every 10 clk):
- req=001 rising → buzzer=1 two cycles later, active_src=001; ack → ack_out=001 for one cycle, buzzer=0, pending=000.
- No ack → after 4 ticks missed pulses once, ack_out=001, state returns to IDLE; a held req=001 does not re-ring.
- Snooze in RING → buzzer=0 for 3 ticks, then buzzer=1 with active_src unchanged; ack clears.
- req=100 ringing, then req=001 rises → chime keeps ringing until ack; 2 cycles later active_src=001.
- Alarm snoozed (active_src=010), timer edge → IDLE, timer rings; after timer ack, alarm re-rings.
- ack and snooze pulsed in the same cycle → ack wins; ack and final timeout tick in the same cycle → missed=0; async reset during RING → buzzer=0 with no clk edge.
